// File: rtl/pipa_pulse_conditioner.sv
// PIPA pulse front-end: synchronises and samples the six accelerometer pulse lines,
// keeps a signed pending count per axis and issues one inc/dec request at a time.
// Optional build macro: PIPA_DROP_ON_FAIL_EN (a both-polarity sample zeroes the axis count).
module pipa_pulse_conditioner #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PIPAXp,
  input  logic             PIPAXm,
  input  logic             PIPAYp,
  input  logic             PIPAYm,
  input  logic             PIPAZp,
  input  logic             PIPAZm,
  input  logic             PIPSAM,
  input  logic             req_ack,
  input  logic             fail_clr,
  output logic             req_valid,
  output logic [1:0]       req_axis,
  output logic             req_minus,
  output logic [CNT_W-1:0] pend_x,
  output logic [CNT_W-1:0] pend_y,
  output logic [CNT_W-1:0] pend_z,
  output logic [2:0]       pipa_fail,
  output logic [2:0]       pend_ovf
);

  localparam logic signed [CNT_W:0] P_MAX = (CNT_W+1)'((1 << (CNT_W-1)) - 1);
  localparam logic signed [CNT_W:0] P_MIN = (CNT_W+1)'(-(1 << (CNT_W-1)));
  localparam logic [CNT_W:0]        ONE   = (CNT_W+1)'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser, one bit pair per axis: {Zm,Zp,Ym,Yp,Xm,Xp}
  // ---------------------------------------------------------------------------
  logic [5:0]                   raw;
  logic [SYNC_STAGES-1:0][5:0]  sync_q;
  logic [5:0]                   syn;

  assign raw = {PIPAZm, PIPAZp, PIPAYm, PIPAYp, PIPAXm, PIPAXp};
  assign syn = sync_q[SYNC_STAGES-1];

  // NOTE: the synchroniser chain is ordinary state, so it takes the async reset too;
  // sequential blocks use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  logic [2:0] samp_p;
  logic [2:0] samp_m;
  logic [2:0] both;

  always_comb begin
    samp_p = '0;
    samp_m = '0;
    for (int a = 0; a < 3; a++) begin
      samp_p[a] = PIPSAM & syn[2*a];
      samp_m[a] = PIPSAM & syn[2*a+1];
    end
  end

  assign both = samp_p & samp_m;

  // ---------------------------------------------------------------------------
  // Request state
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [1:0] axis_q, axis_d;
  logic       minus_q, minus_d;
  logic [1:0] last_q, last_d;
  logic       ack_fire;

  assign ack_fire = (state_q == S_REQ) && req_ack;

  // ---------------------------------------------------------------------------
  // Pending counters
  // ---------------------------------------------------------------------------
  logic [2:0][CNT_W-1:0] pend_q, pend_d;
  logic [2:0]            fail_q, fail_d;
  logic [2:0]            ovf_q, ovf_d;
  logic [2:0]            ovf_set;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    logic [CNT_W:0] s_delta;
    logic [CNT_W:0] a_delta;
    logic [CNT_W:0] sum;
    pend_d  = pend_q;
    ovf_set = '0;
    s_delta = '0;
    a_delta = '0;
    sum     = '0;
    for (int a = 0; a < 3; a++) begin
      s_delta = '0;
      if (samp_p[a] && !samp_m[a]) begin
        s_delta = ONE;
      end else if (samp_m[a] && !samp_p[a]) begin
        s_delta = '1;
      end
      // An ack retires one unit of the outstanding request, so it moves the count toward 0.
      a_delta = '0;
      if (ack_fire && (axis_q == 2'(a))) begin
        a_delta = minus_q ? ONE : '1;
      end
      sum = {pend_q[a][CNT_W-1], pend_q[a]} + s_delta + a_delta;
      if ($signed(sum) > P_MAX) begin
        pend_d[a]  = P_MAX[CNT_W-1:0];
        ovf_set[a] = 1'b1;
      end else if ($signed(sum) < P_MIN) begin
        pend_d[a]  = P_MIN[CNT_W-1:0];
        ovf_set[a] = 1'b1;
      end else begin
        pend_d[a] = sum[CNT_W-1:0];
      end
`ifdef PIPA_DROP_ON_FAIL_EN
      if (both[a]) begin
        pend_d[a]  = '0;
        ovf_set[a] = 1'b0;
      end
`endif
    end
  end

  // A new error in the same cycle as fail_clr still lands.
  assign fail_d = (fail_clr ? 3'b000 : fail_q) | both;
  assign ovf_d  = (fail_clr ? 3'b000 : ovf_q)  | ovf_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      fail_q <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= pend_d;
      fail_q <= fail_d;
      ovf_q  <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick, starting after the last-served axis
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] rr_next(input logic [1:0] a);
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

  logic [2:0] nz;
  logic       found;
  logic [1:0] pick;
  logic [1:0] cand;

  always_comb begin
    for (int a = 0; a < 3; a++) begin
      nz[a] = |pend_q[a];
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    cand  = last_q;
    for (int k = 0; k < 3; k++) begin
      cand = rr_next(cand);
      if (!found && nz[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      axis_q  <= 2'd0;
      minus_q <= 1'b0;
      last_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      axis_q  <= axis_d;
      minus_q <= minus_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    axis_d  = axis_q;
    minus_d = minus_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_REQ;
          axis_d  = pick;
          minus_d = pend_q[pick][CNT_W-1];
        end
      end
      S_REQ: begin
        // Held until acked even if the count has since crossed zero.
        if (req_ack) begin
          state_d = S_IDLE;
          last_d  = axis_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_valid = (state_q == S_REQ);
  assign req_axis  = axis_q;
  assign req_minus = minus_q;
  assign pend_x    = pend_q[0];
  assign pend_y    = pend_q[1];
  assign pend_z    = pend_q[2];
  assign pipa_fail = fail_q;
  assign pend_ovf  = ovf_q;

endmodule

// File: tb/tb_pipa_pulse_conditioner.sv
// Self-checking bench for pipa_pulse_conditioner: directed test-plan steps then a random
// phase, all compared every cycle against a behavioural model of the pending-count rules.
module tb_pipa_pulse_conditioner;

  localparam int CNT_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int P_MAX       = (1 << (CNT_W-1)) - 1;
  localparam int P_MIN       = -(1 << (CNT_W-1));

  logic             clk = 1'b0;
  logic             rst;
  logic             PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm;
  logic             PIPSAM, req_ack, fail_clr;
  logic             req_valid;
  logic [1:0]       req_axis;
  logic             req_minus;
  logic [CNT_W-1:0] pend_x, pend_y, pend_z;
  logic [2:0]       pipa_fail, pend_ovf;

  always #5 clk = ~clk;

  pipa_pulse_conditioner #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst),
    .PIPAXp(PIPAXp), .PIPAXm(PIPAXm), .PIPAYp(PIPAYp),
    .PIPAYm(PIPAYm), .PIPAZp(PIPAZp), .PIPAZm(PIPAZm),
    .PIPSAM(PIPSAM), .req_ack(req_ack), .fail_clr(fail_clr),
    .req_valid(req_valid), .req_axis(req_axis), .req_minus(req_minus),
    .pend_x(pend_x), .pend_y(pend_y), .pend_z(pend_z),
    .pipa_fail(pipa_fail), .pend_ovf(pend_ovf)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int         m_pend [3];
  bit [2:0]   m_fail, m_ovf;
  bit         m_busy;
  int         m_axis;
  bit         m_minus;
  int         m_last;
  logic [5:0] m_hist [$];   // raw line values, newest first

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 3; a++) m_pend[a] = 0;
    m_fail  = '0;
    m_ovf   = '0;
    m_busy  = 1'b0;
    m_axis  = 0;
    m_minus = 1'b0;
    m_last  = 0;
    m_hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(6'd0);
  endtask

  // One clock of the specified behaviour, evaluated from pre-edge inputs and state.
  task automatic model_step();
    logic [5:0] raw, seen;
    int         nxt [3];
    int         d;
    bit         p, m, clamp, hit;
    raw  = {PIPAZm, PIPAZp, PIPAYm, PIPAYp, PIPAXm, PIPAXp};
    seen = m_hist[SYNC_STAGES-1];
    m_hist.push_front(raw);
    void'(m_hist.pop_back());
    if (fail_clr) begin
      m_fail = '0;
      m_ovf  = '0;
    end
    for (int a = 0; a < 3; a++) begin
      p = PIPSAM && seen[2*a];
      m = PIPSAM && seen[2*a+1];
      d = 0;
      if (p && !m) d = 1;
      else if (m && !p) d = -1;
      if (m_busy && req_ack && m_axis == a) d += m_minus ? 1 : -1;
      nxt[a] = m_pend[a] + d;
      clamp  = 1'b0;
      if (nxt[a] > P_MAX) begin nxt[a] = P_MAX; clamp = 1'b1; end
      if (nxt[a] < P_MIN) begin nxt[a] = P_MIN; clamp = 1'b1; end
      if (p && m) begin
        m_fail[a] = 1'b1;
`ifdef PIPA_DROP_ON_FAIL_EN
        nxt[a] = 0;
        clamp  = 1'b0;
`endif
      end
      if (clamp) m_ovf[a] = 1'b1;
    end
    if (!m_busy) begin
      hit = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        if (!hit && m_pend[(m_last + k) % 3] != 0) begin
          hit     = 1'b1;
          m_busy  = 1'b1;
          m_axis  = (m_last + k) % 3;
          m_minus = m_pend[m_axis] < 0;
        end
      end
    end else if (req_ack) begin
      m_busy = 1'b0;
      m_last = m_axis;
    end
    for (int a = 0; a < 3; a++) m_pend[a] = nxt[a];
  endtask

  task automatic compare_all();
    check("req_valid", req_valid, m_busy);
    if (m_busy) begin
      check("req_axis", req_axis, m_axis);
      check("req_minus", req_minus, m_minus);
    end
    check("pend_x", $signed(pend_x), m_pend[0]);
    check("pend_y", $signed(pend_y), m_pend[1]);
    check("pend_z", $signed(pend_z), m_pend[2]);
    check("pipa_fail", pipa_fail, m_fail);
    check("pend_ovf", pend_ovf, m_ovf);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic settle();
    repeat (SYNC_STAGES + 1) tick();
  endtask

  task automatic strobe();
    PIPSAM = 1'b1;
    tick();
    PIPSAM = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (req_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check(tag, req_valid, 1);
  endtask

  task automatic ack_expect(input int exp_axis, input int exp_minus);
    wait_valid("ack_wait_valid");
    check("ack_axis", req_axis, exp_axis);
    check("ack_minus", req_minus, exp_minus);
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
  endtask

  task automatic drain();
    req_ack = 1'b1;
    repeat (30) tick();
    req_ack = 1'b0;
    tick();
    check("drain_x", $signed(pend_x), 0);
    check("drain_y", $signed(pend_y), 0);
    check("drain_z", $signed(pend_z), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, req_valid, 0);
    check({tag, "_axis"}, req_axis, 0);
    check({tag, "_minus"}, req_minus, 0);
    check({tag, "_px"}, pend_x, 0);
    check({tag, "_py"}, pend_y, 0);
    check({tag, "_pz"}, pend_z, 0);
    check({tag, "_fail"}, pipa_fail, 0);
    check({tag, "_ovf"}, pend_ovf, 0);
  endtask

  initial begin
    int exp_x;
    rst = 1'b0;
    {PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm} = '0;
    PIPSAM = 1'b0; req_ack = 1'b0; fail_clr = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // X plus held over three strobes, then three acks
    PIPAXp = 1'b1;
    settle();
    repeat (3) strobe();
    check("t1_pend_x", $signed(pend_x), 3);
    check("t1_valid", req_valid, 1);
    check("t1_axis", req_axis, 0);
    check("t1_minus", req_minus, 0);
    PIPAXp = 1'b0;
    repeat (3) ack_expect(0, 0);
    tick();
    tick();
    check("t1_end_x", $signed(pend_x), 0);
    check("t1_end_valid", req_valid, 0);

    // Y minus and Z plus on one strobe: served Y then Z
    PIPAYm = 1'b1; PIPAZp = 1'b1;
    settle();
    strobe();
    PIPAYm = 1'b0; PIPAZp = 1'b0;
    ack_expect(1, 1);
    ack_expect(2, 0);
    tick();
    tick();
    check("t2_y", $signed(pend_y), 0);
    check("t2_z", $signed(pend_z), 0);

    // Both X polarities at a strobe, with a count already pending
    PIPAXp = 1'b1;
    settle();
    strobe();
    PIPAXm = 1'b1;
    settle();
    strobe();
    PIPAXp = 1'b0; PIPAXm = 1'b0;
`ifdef PIPA_DROP_ON_FAIL_EN
    exp_x = 0;
`else
    exp_x = 1;
`endif
    check("t3_fail", pipa_fail, 3'b001);
    check("t3_pend_x", $signed(pend_x), exp_x);
    fail_clr = 1'b1;
    tick();
    fail_clr = 1'b0;
    check("t3_fail_clr", pipa_fail, 3'b000);
    drain();

    // Z saturation
    PIPAZp = 1'b1;
    settle();
    repeat (8) strobe();
    PIPAZp = 1'b0;
    check("t4_pend_z", $signed(pend_z), P_MAX);
    check("t4_ovf", pend_ovf, 3'b100);
    fail_clr = 1'b1;
    tick();
    fail_clr = 1'b0;
    check("t4_ovf_clr", pend_ovf, 3'b000);
    drain();

    // Minus sample netted against the ack of an outstanding plus request
    PIPAXp = 1'b1;
    settle();
    strobe();
    PIPAXp = 1'b0;
    wait_valid("t5_valid");
    check("t5_minus0", req_minus, 0);
    PIPAXm = 1'b1;
    settle();
    PIPSAM = 1'b1; req_ack = 1'b1;
    tick();
    PIPSAM = 1'b0; req_ack = 1'b0; PIPAXm = 1'b0;
    check("t5_pend_x", $signed(pend_x), -1);
    wait_valid("t5_valid2");
    check("t5_axis", req_axis, 0);
    check("t5_minus1", req_minus, 1);
    drain();

    // Asynchronous reset in the middle of a request
    PIPAYp = 1'b1;
    settle();
    repeat (2) strobe();
    PIPAYp = 1'b0;
    wait_valid("t6_valid");
    check("t6_pend_y", $signed(pend_y), 2);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("t6_async");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) tick();
    check("t6_no_req", req_valid, 0);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      PIPAXp   = ($urandom_range(3) == 0);
      PIPAXm   = ($urandom_range(3) == 0);
      PIPAYp   = ($urandom_range(3) == 0);
      PIPAYm   = ($urandom_range(3) == 0);
      PIPAZp   = ($urandom_range(3) == 0);
      PIPAZm   = ($urandom_range(3) == 0);
      PIPSAM   = ($urandom_range(3) == 0);
      req_ack  = ($urandom_range(1) == 1);
      fail_clr = ($urandom_range(15) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipa_pulse_conditioner.md
Name: pipa_pulse_conditioner

Overview:
- Front-end for the accelerometer (PIPA) inputs of the counter-increment logic.
- Synchronises the six raw PIPA pulse lines and samples them on the PIPA sample strobe.
- Keeps a signed pending-count per axis and issues increment/decrement requests, one at a time, to the downstream counter module over a valid/ack handshake.
- Flags illegal simultaneous plus/minus samples and counter overflow.

Parameters:
- CNT_W, 4: width of each per-axis signed pending counter, two's complement. Range is -2^(CNT_W-1) to 2^(CNT_W-1)-1.
- SYNC_STAGES, 2: number of synchroniser flops on each raw pulse input. Minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low. All state clears while rst=0.
- PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm  in  1 each  raw accelerometer pulses, active-high, asynchronous to clk.
- PIPSAM  in  1  sample strobe, one clk wide.
- req_ack  in  1  downstream accepts the current request.
- fail_clr  in  1  clears the fail and overflow flags.
- req_valid  out  1  a request is pending.
- req_axis  out  2  axis of the request: 0=X, 1=Y, 2=Z. Value 3 is never driven.
- req_minus  out  1  1 = decrement request, 0 = increment request.
- pend_x, pend_y, pend_z  out  CNT_W each  per-axis signed pending counts.
- pipa_fail  out  3  sticky both-polarity error, one bit per axis: bit0=X, bit1=Y, bit2=Z.
- pend_ovf  out  3  sticky saturation flag, one bit per axis, same bit order.

Behaviour:
- Reset values: every output is 0, synchroniser flops are 0, the round-robin pointer is X.
- Synchronisation:
  - Each raw input passes through SYNC_STAGES flops.
  - On the PIPSAM cycle, each axis samples its synchronised p/m pair.
  - Inputs are level-sampled. There is no edge detection.
- Sample delta per axis:
  - p only: +1.
  - m only: -1.
  - neither: 0.
  - both: 0, and the axis's pipa_fail bit is set.
- Ack delta: applies only to the axis currently on req_axis, and only when req_valid=1 and req_ack=1.
  - req_minus=0: -1.
  - req_minus=1: +1.
- Counter update:
  - Next value = pend + sample_delta + ack_delta, computed in CNT_W+1 bits.
  - Result is clamped to the CNT_W range. If clamping occurs, the axis's pend_ovf bit is set.
  - A sample and an ack on the same axis in the same cycle net correctly. Example: pend=+1 with a + request outstanding, a minus sample arrives and the + request is acked; pend ends at -1.
- Request state machine:
  - IDLE:
    - If any pending count is nonzero, pick the first nonzero axis in round-robin order, starting after the last-served axis.
    - Register req_axis and req_minus (req_minus = sign bit of pend) and go to REQ.
    - req_valid rises one cycle after pend becomes nonzero.
  - REQ:
    - req_valid=1. req_axis and req_minus hold stable until the ack.
    - On req_ack: apply the ack delta, update the last-served pointer, return to IDLE. req_valid drops the next cycle.
    - No back-to-back requests: there is at least one IDLE cycle between requests.
  - If the requested axis's pend changes sign or reaches 0 while in REQ, the request is still held and must be acked. The ack delta then restores the correct net count.
  - req_ack while req_valid=0 is ignored.
- Flags:
  - fail_clr clears pipa_fail and pend_ovf.
  - If fail_clr coincides with a new error, set wins.
  - Counts are never cleared by fail_clr.
- PIPSAM with no raw inputs active has no effect.
- rst taken low mid-request: req_valid drops immediately (asynchronous) and all counts clear.

Optional Feature:
- Macro: PIPA_DROP_ON_FAIL_EN.
- Defined: a both-polarity sample clears that axis's pending count to 0 on that cycle and overrides any ack delta.
  - If that axis currently has a request outstanding, the request is still held until acked. Its ack delta is then applied to the cleared count.
- Undefined: a both-polarity sample only sets pipa_fail, and the pending count is retained.

Test Plan:
- PIPAXp=1 held, three PIPSAM strobes, no ack -> pend_x=3; req_valid=1 with req_axis=0, req_minus=0; acking three times -> pend_x=0 and req_valid=0.
- PIPAYm=1 and PIPAZp=1 on one PIPSAM, ack every request -> requests served in order Y (minus), then Z (plus); both counts end at 0.
- PIPAXp and PIPAXm both high at PIPSAM -> pipa_fail=3'b001, pend_x unchanged (macro off) or 0 (macro on); fail_clr -> pipa_fail=0.
- Eight PIPAZp samples with CNT_W=4, no ack -> pend_z saturates at 7 and pend_ovf[2]=1.
- pend_x=+1 with a + request outstanding, PIPAXm sample in the same cycle as req_ack -> pend_x=-1, then the next request is X with req_minus=1.
- rst pulled low while req_valid=1 and pend_y=2 -> all outputs 0 asynchronously; after release, no request until a new sample arrives.
